// File: rtl/router_out_arbiter.sv
// Output-port arbiter for a router: round-robin selection among n_in input
// FIFOs, then a single-word transfer to the downstream FIFO. Flow control
// towards the FIFOs is handled by push_dst/pop_out.
module router_out_arbiter #(
    parameter int unsigned pckg_sz = 40,
    parameter int unsigned n_in    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [n_in-1:0]         pndng_in,
    input  logic [n_in*pckg_sz-1:0] data_in,
    output logic [n_in-1:0]         pop_out,
    input  logic                    full_dst,
    output logic                    push_dst,
    output logic [pckg_sz-1:0]      data_dst,
    output logic [n_in-1:0]         grant,
    output logic [15:0]             sent_cnt
);

    localparam int unsigned IDX_W = (n_in > 1) ? $clog2(n_in) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     gidx;
    logic [IDX_W-1:0]     win;
    logic [pckg_sz-1:0]   win_data;
    logic                 found;
    logic                 gnt_pend;

    // Binary index of the current owner and whether it is still pending
    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < n_in; i++) begin
            if (grant[i]) begin
                gidx = IDX_W'(i);
            end
        end
        gnt_pend = |(pndng_in & grant);
    end

    // Round-robin search starting just after the last served port
    always_comb begin
        win      = last;
        found    = 1'b0;
        win_data = '0;
        for (int unsigned k = 1; k <= n_in; k++) begin
            if (!found && pndng_in[IDX_W'((32'(last) + k) % n_in)]) begin
                win   = IDX_W'((32'(last) + k) % n_in);
                found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < n_in; i++) begin
            if (win == IDX_W'(i)) begin
                win_data = data_in[i*pckg_sz +: pckg_sz];
            end
        end
    end

    // Transfer strobes fire in SEND when the owner still has data and there is room
    assign push_dst = (state == SEND) && gnt_pend && !full_dst;
    assign pop_out  = push_dst ? grant : '0;

    // Arbitration FSM with grant, captured word, priority pointer and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            data_dst <= '0;
            sent_cnt <= '0;
            last     <= IDX_W'(n_in - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|pndng_in) begin
                        grant    <= n_in'(1) << win;
                        data_dst <= win_data;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!gnt_pend) begin
                        grant <= '0;
                        state <= IDLE;
                    end else if (!full_dst) begin
                        last     <= gidx;
                        sent_cnt <= sent_cnt + CNT_W'(1);
                        grant    <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/router_out_arbiter.md
ROUTER_OUT_ARBITER -- requirements
Module: router_out_arbiter

Interface
REQ-001 The block SHALL have parameter pckg_sz, default 40, meaning the packet word width in bits.
REQ-002 The block SHALL have parameter n_in, default 4, meaning the number of requesting input FIFOs.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port pndng_in, input, n_in bits: bit i high means input FIFO i has a packet at its head.
REQ-006 The block SHALL have port data_in, input, n_in*pckg_sz bits: head word of FIFO i in slice [i*pckg_sz +: pckg_sz].
REQ-007 The block SHALL have port pop_out, output, n_in bits: one-cycle pop strobe to input FIFO i.
REQ-008 The block SHALL have port full_dst, input, 1 bit: the downstream FIFO is full.
REQ-009 The block SHALL have port push_dst, output, 1 bit: one-cycle push strobe to the downstream FIFO.
REQ-010 The block SHALL have port data_dst, output, pckg_sz bits: the word being pushed downstream.
REQ-011 The block SHALL have port grant, output, n_in bits: one-hot index of the current owner, zero when idle.
REQ-012 The block SHALL have port sent_cnt, output, 16 bits: count of completed transfers.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and SEND.
REQ-014 In IDLE with any pndng_in bit high, the block SHALL pick the winner round-robin, searching from index last+1 upward modulo n_in.
REQ-015 On that edge the block SHALL set grant one-hot to the winner, capture data_dst from the winner's data_in slice, and go to SEND.
REQ-016 In IDLE with pndng_in all zero, the block SHALL hold state, with grant at zero and data_dst unchanged.
REQ-017 In SEND with full_dst=0 and pndng_in[granted]=1, the block SHALL assert push_dst and pop_out[granted] combinationally in the same cycle.
REQ-018 On the edge ending a transfer cycle (REQ-017), the block SHALL update last to the granted index, increment sent_cnt, clear grant, and return to IDLE.
REQ-019 In SEND with full_dst=1, the block SHALL keep push_dst and pop_out at 0, hold grant and data_dst, and remain in SEND indefinitely.
REQ-020 In SEND, if pndng_in[granted] falls, the block SHALL abort to IDLE without push or pop, with last and sent_cnt unchanged; this takes priority over REQ-017 and REQ-019.
REQ-021 Latency from pndng_in sampled high in IDLE to push_dst SHALL be exactly one cycle when full_dst=0.
REQ-022 Peak throughput SHALL be one packet per two cycles.
REQ-023 pop_out SHALL never have more than one bit high.
REQ-024 pop_out SHALL be high only in a cycle where push_dst is high.
REQ-025 sent_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-026 Requests arriving while in SEND SHALL be considered only at the next IDLE arbitration.

Reset
REQ-027 While reset is high, the block SHALL immediately force IDLE, grant=0, push_dst=0, pop_out=0, data_dst=0, sent_cnt=0, and last=n_in-1, so that port 0 has first priority.
REQ-028 Reset asserted during SEND SHALL drop the transfer with no push or pop, and the granted FIFO SHALL keep its packet.
REQ-029 After reset deasserts, the first arbitration SHALL occur on the first rising edge with any pndng_in high.

Verification
REQ-030 Single requester: pndng_in=4'b0100, slice 2 = 0xA5, full_dst=0 -> grant=4'b0100 after edge 1; push_dst=1, pop_out=4'b0100, data_dst=0xA5 in cycle 2; sent_cnt=1 after edge 2.
REQ-031 All four pending continuously, full_dst=0 -> pushes in order 0,1,2,3,0 at cycles 2,4,6,8,10.
REQ-032 full_dst=1 for 5 cycles in SEND -> no push or pop for those 5 cycles, data_dst stable; push occurs in the first cycle full_dst=0.
REQ-033 Reset pulse mid-SEND with port 3 granted -> all outputs 0 immediately; with all ports then pending, port 0 is served first.
REQ-034 pndng_in[granted] drops in SEND -> no push, return to IDLE, last unchanged; same port wins again if it re-requests alone.
REQ-035 sent_cnt preloaded to 0xFFFF by 65535 transfers, plus one more transfer -> sent_cnt=0x0000.
